if_fetch_unit: RTL and testbench

//  Instruction-fetch stage upstream of the multi-cycle decode/execute core. Owns the PC, issues

---
 rtl/if_fetch_unit_pkg.sv | 11 +
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit.sv | 61 ++++++
 tb/tb_if_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_pkg: fetch-stage state encodings and shared constants.
package if_pkg;
  typedef enum logic [2:0] {
    IF_IDLE = 3'd0,
    IF_REQ  = 3'd1,
    IF_RESP = 3'd2,
    IF_HOLD = 3'd3
  } if_state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
  localparam logic [31:0] LA32_NOP     = 32'h03400000;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: inst SRAM port, decode handshake and redirect bundle around the fetch stage.
interface if_fetch_unit_if #(parameter int PC_W = 32);
  logic            inst_sram_en;
  logic            inst_sram_we;
  logic [PC_W-1:0] inst_sram_addr;
  logic [31:0]     inst_sram_rdata;
  logic            id_allowin;
  logic            br_redirect;
  logic [PC_W-1:0] br_target;
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_inst;
  logic            if_adef;
  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, if_valid, if_pc, if_inst, if_adef,
    input  inst_sram_rdata, id_allowin, br_redirect, br_target
  );
  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, if_valid, if_pc, if_inst, if_adef,
    output inst_sram_rdata, id_allowin, br_redirect, br_target
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing 1-cycle-latency SRAM fetches, buffering the word while decode stalls.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input logic         clk,
  input logic         reset,
  if_fetch_unit_if.master bus
);
  if_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     buf_q, buf_d;
  logic            aligned, presenting, xfer;
  logic [31:0]     inst;
  assign aligned    = pc_q[1:0] == 2'b00;
  assign presenting = (state_q == IF_RESP) || (state_q == IF_HOLD);
  assign inst       = (state_q == IF_HOLD) ? buf_q :
                      (state_q == IF_RESP && aligned) ? bus.inst_sram_rdata : 32'h0;
  // Misaligned PCs never reach the SRAM; they surface only through if_adef.
  assign bus.inst_sram_en   = (state_q == IF_REQ) && aligned;
  assign bus.inst_sram_we   = 1'b0;
  assign bus.inst_sram_addr = pc_q;
  assign bus.if_valid       = presenting && !bus.br_redirect;
  assign bus.if_pc          = pc_q;
  assign bus.if_inst        = inst;
  assign bus.if_adef        = presenting && !aligned;
  assign xfer               = bus.if_valid && bus.id_allowin;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (bus.br_redirect) begin
      state_d = IF_REQ;
      pc_d    = bus.br_target;
    end else begin
      unique case (state_q)
        IF_IDLE: state_d = IF_REQ;
        IF_REQ:  state_d = IF_RESP;
        IF_RESP, IF_HOLD: begin
          state_d = xfer ? IF_REQ : IF_HOLD;
          pc_d    = xfer ? pc_q + PC_W'(4) : pc_q;
          buf_d   = xfer ? buf_q : inst;
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus a randomized transaction-level scoreboard for the fetch stage.
module tb_if_fetch_unit;
  import if_pkg::*;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  logic clk, reset;
  int checks, errors;
  logic [31:0] poke_addr, poke_data;
  if_fetch_unit_if #(.PC_W(32)) bus();
  if_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus.master));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // Synchronous SRAM: data from the addressed word one cycle after en, otherwise toggles.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == poke_addr) ? poke_data : ((a * 32'h9e3779b1) ^ 32'h0badf00d);
  endfunction
  always @(posedge clk)
    bus.inst_sram_rdata <= bus.inst_sram_en ? mem_word(bus.inst_sram_addr) : ~bus.inst_sram_rdata;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #2;
  endtask
  task automatic test_reset;
    reset = 1'b1; bus.id_allowin = 1'b1;
    repeat (2) tick();
    settle();
    checks++; if (bus.inst_sram_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%0h exp=0", bus.inst_sram_en); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", bus.if_valid); end
    checks++; if (bus.if_adef !== 1'b0) begin errors++; $display("FAIL rst_adef got=%0h exp=0", bus.if_adef); end
    checks++; if (bus.if_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=0", bus.if_inst); end
    checks++; if (bus.if_pc !== RST_PC) begin errors++; $display("FAIL rst_pc got=%h exp=%h", bus.if_pc, RST_PC); end
    tick(); reset = 1'b0; settle();
    checks++; if (bus.inst_sram_en !== 1'b0) begin errors++; $display("FAIL idle_en got=%0h exp=0", bus.inst_sram_en); end
    tick(); settle();
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC) begin errors++; $display("FAIL first_req en=%0h addr=%h exp en=1 addr=%h", bus.inst_sram_en, bus.inst_sram_addr, RST_PC); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL req_valid got=%0h exp=0", bus.if_valid); end
    tick(); settle();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== RST_PC) begin errors++; $display("FAIL first_resp valid=%0h pc=%h exp 1/%h", bus.if_valid, bus.if_pc, RST_PC); end
    checks++; if (bus.if_inst !== mem_word(RST_PC)) begin errors++; $display("FAIL first_inst got=%h exp=%h", bus.if_inst, mem_word(RST_PC)); end
    tick(); settle();
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC + 4) begin errors++; $display("FAIL second_req en=%0h addr=%h exp 1/%h", bus.inst_sram_en, bus.inst_sram_addr, RST_PC + 4); end
  endtask
  task automatic test_stall;
    poke_addr = RST_PC + 4; poke_data = 32'h02800421;
    bus.id_allowin = 1'b0;
    tick(); settle();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h02800421) begin errors++; $display("FAIL stall_resp valid=%0h inst=%h exp 1/02800421", bus.if_valid, bus.if_inst); end
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      checks++; if (bus.if_inst !== 32'h02800421 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d inst=%h valid=%0h exp 02800421/1", i, bus.if_inst, bus.if_valid); end
      checks++; if (bus.inst_sram_en !== 1'b0) begin errors++; $display("FAIL stall_en%0d got=%0h exp=0", i, bus.inst_sram_en); end
    end
    tick(); bus.id_allowin = 1'b1; settle();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== RST_PC + 4) begin errors++; $display("FAIL stall_release valid=%0h pc=%h exp 1/%h", bus.if_valid, bus.if_pc, RST_PC + 4); end
    tick(); settle();
    checks++; if (bus.if_valid !== 1'b0 || bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC + 8) begin errors++; $display("FAIL stall_next valid=%0h en=%0h addr=%h exp 0/1/%h", bus.if_valid, bus.inst_sram_en, bus.inst_sram_addr, RST_PC + 8); end
    poke_addr = '1;
  endtask
  task automatic test_redirect_resp;
    tick(); bus.br_redirect = 1'b1; bus.br_target = 32'h1c000100; settle();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_resp_valid got=%0h exp=0", bus.if_valid); end
    tick(); bus.br_redirect = 1'b0; settle();
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c000100 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_resp_req en=%0h addr=%h valid=%0h exp 1/1c000100/0", bus.inst_sram_en, bus.inst_sram_addr, bus.if_valid); end
    tick(); settle();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h1c000100 || bus.if_inst !== mem_word(32'h1c000100)) begin errors++; $display("FAIL redir_resp_deliver valid=%0h pc=%h inst=%h exp pc 1c000100 inst %h", bus.if_valid, bus.if_pc, bus.if_inst, mem_word(32'h1c000100)); end
  endtask
  task automatic test_redirect_req;
    reset = 1'b1; tick(); reset = 1'b0; bus.id_allowin = 1'b1;
    repeat (5) tick();
    bus.br_redirect = 1'b1; bus.br_target = 32'h1c000040; settle();
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c000008) begin errors++; $display("FAIL redir_req_old en=%0h addr=%h exp 1/1c000008", bus.inst_sram_en, bus.inst_sram_addr); end
    tick(); bus.br_redirect = 1'b0; settle();
    checks++; if (bus.if_valid !== 1'b0 || bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c000040) begin errors++; $display("FAIL redir_req_new valid=%0h en=%0h addr=%h exp 0/1/1c000040", bus.if_valid, bus.inst_sram_en, bus.inst_sram_addr); end
    tick(); settle();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h1c000040 || bus.if_inst !== mem_word(32'h1c000040)) begin errors++; $display("FAIL redir_req_deliver valid=%0h pc=%h inst=%h exp 1/1c000040/%h", bus.if_valid, bus.if_pc, bus.if_inst, mem_word(32'h1c000040)); end
  endtask
  task automatic test_misaligned;
    bus.br_redirect = 1'b1; bus.br_target = 32'h1c000002; settle();
    tick(); bus.br_redirect = 1'b0; settle();
    checks++; if (bus.inst_sram_en !== 1'b0 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL mis_req en=%0h valid=%0h exp 0/0", bus.inst_sram_en, bus.if_valid); end
    tick(); settle();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_adef !== 1'b1 || bus.if_inst !== 32'h0 || bus.if_pc !== 32'h1c000002) begin errors++; $display("FAIL mis_resp valid=%0h adef=%0h inst=%h pc=%h exp 1/1/0/1c000002", bus.if_valid, bus.if_adef, bus.if_inst, bus.if_pc); end
    tick(); settle();
    checks++; if (bus.inst_sram_en !== 1'b0 || bus.inst_sram_addr !== 32'h1c000006) begin errors++; $display("FAIL mis_next en=%0h addr=%h exp 0/1c000006", bus.inst_sram_en, bus.inst_sram_addr); end
  endtask
  task automatic test_async_reset;
    bus.br_redirect = 1'b1; bus.br_target = 32'h1c000200; bus.id_allowin = 1'b0;
    tick(); bus.br_redirect = 1'b0;
    tick(); tick(); settle();
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%0h exp=1", bus.if_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.if_pc !== RST_PC || bus.inst_sram_en !== 1'b0 || bus.if_inst !== 32'h0) begin errors++; $display("FAIL async_rst valid=%0h pc=%h en=%0h inst=%h exp 0/%h/0/0", bus.if_valid, bus.if_pc, bus.inst_sram_en, bus.if_inst, RST_PC); end
    tick(); reset = 1'b0; bus.id_allowin = 1'b1; settle();
    tick(); settle();
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC) begin errors++; $display("FAIL restart en=%0h addr=%h exp 1/%h", bus.inst_sram_en, bus.inst_sram_addr, RST_PC); end
    bus.br_redirect = 1'b1; bus.br_target = 32'hfffffffc;
    tick(); bus.br_redirect = 1'b0; settle();
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'hfffffffc) begin errors++; $display("FAIL wrap_req en=%0h addr=%h exp 1/fffffffc", bus.inst_sram_en, bus.inst_sram_addr); end
    tick(); settle();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hfffffffc) begin errors++; $display("FAIL wrap_resp valid=%0h pc=%h exp 1/fffffffc", bus.if_valid, bus.if_pc); end
    tick(); settle();
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h0) begin errors++; $display("FAIL wrap_next en=%0h addr=%h exp 1/00000000", bus.inst_sram_en, bus.inst_sram_addr); end
  endtask
  task automatic test_back_to_back;
    int n;
    logic [31:0] exp_pc;
    n = 0; exp_pc = RST_PC;
    reset = 1'b1; tick(); reset = 1'b0; bus.id_allowin = 1'b1; settle();
    for (int i = 0; i < 21; i++) begin
      if (bus.if_valid && bus.id_allowin) begin
        checks++; if (bus.if_pc !== exp_pc) begin errors++; $display("FAIL b2b_pc got=%h exp=%h", bus.if_pc, exp_pc); end
        exp_pc = exp_pc + 4; n++;
      end
      tick(); settle();
    end
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_throughput got=%0d exp=10", n); end
  endtask
  task automatic test_random;
    logic [31:0] exp_pc;
    int starve, xfers;
    exp_pc = RST_PC; starve = 0; xfers = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      bus.id_allowin  = $urandom_range(0, 3) != 0;
      bus.br_redirect = $urandom_range(0, 9) == 0;
      bus.br_target   = RST_PC + ($urandom_range(0, 255) << 2) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      settle();
      if (bus.inst_sram_en) begin
        checks++; if (bus.inst_sram_addr !== exp_pc || exp_pc[1:0] != 2'b00) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, bus.inst_sram_addr, exp_pc); end
      end
      if (bus.if_valid) begin
        checks++; if (bus.if_pc !== exp_pc || bus.if_adef !== (exp_pc[1:0] != 2'b00)) begin errors++; $display("FAIL rnd_pc cyc=%0d pc=%h adef=%0h exp pc=%h", i, bus.if_pc, bus.if_adef, exp_pc); end
        checks++; if (bus.if_inst !== ((exp_pc[1:0] == 2'b00) ? mem_word(exp_pc) : 32'h0)) begin errors++; $display("FAIL rnd_inst cyc=%0d got=%h pc=%h", i, bus.if_inst, exp_pc); end
      end
      if (bus.br_redirect) begin
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rnd_redir_mask cyc=%0d valid=%0h exp=0", i, bus.if_valid); end
        exp_pc = bus.br_target; starve = 0;
      end else if (bus.if_valid && bus.id_allowin) begin
        exp_pc = exp_pc + 4; starve = 0; xfers++;
      end else if (bus.id_allowin) starve++;
      checks++; if (starve > 2) begin errors++; $display("FAIL rnd_starve cyc=%0d count=%0d limit=2", i, starve); end
      tick();
    end
    bus.br_redirect = 1'b0;
    checks++; if (xfers < 100) begin errors++; $display("FAIL rnd_xfers got=%0d exp>=100", xfers); end
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; poke_addr = '1; poke_data = LA32_NOP;
    bus.id_allowin = 1'b0; bus.br_redirect = 1'b0; bus.br_target = '0;
    #1;
    test_reset();
    test_stall();
    test_redirect_resp();
    test_redirect_req();
    test_misaligned();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
